// File: rtl/ibex_rvfi_trace_packer.sv
// RVFI retirement records -> FIFO -> 32-bit packet stream (header, pc, insn, rd_wdata[, mem_addr, mem_data]).
// Define IBEX_RVFI_TRACE_MEM_EN to append memory words for records with a non-zero byte mask.
module ibex_rvfi_trace_packer #(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rvfi_valid_i,
  input  logic [63:0]              rvfi_order_i,
  input  logic [31:0]              rvfi_insn_i,
  input  logic [31:0]              rvfi_pc_rdata_i,
  input  logic [4:0]               rvfi_rd_addr_i,
  input  logic [31:0]              rvfi_rd_wdata_i,
  input  logic                     rvfi_trap_i,
  input  logic                     rvfi_intr_i,
  input  logic                     rvfi_halt_i,
  input  logic [1:0]               rvfi_mode_i,
  input  logic [31:0]              rvfi_mem_addr_i,
  input  logic [3:0]               rvfi_mem_rmask_i,
  input  logic [3:0]               rvfi_mem_wmask_i,
  input  logic [31:0]              rvfi_mem_rdata_i,
  input  logic [31:0]              rvfi_mem_wdata_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_data_o,
  output logic                     trace_last_o,
  output logic [15:0]              drop_cnt_o,
  output logic [$clog2(Depth):0]   fifo_level_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [5:0]  order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
    logic        halt;
    logic [1:0]  mode;
    logic        ovf;
`ifdef IBEX_RVFI_TRACE_MEM_EN
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
`endif
  } rec_t;

  typedef enum logic [2:0] {IDLE, HDR, PC, INSN, WDATA, MADDR, MDATA} state_e;

  rec_t          mem_q [Depth];
  rec_t          wr_rec, cur_q, nxt_rec, next_head;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0] level_q;
  logic [15:0]   drop_q;
  logic          ovf_q;
  state_e        state_q, state_d;
  logic [31:0]   data_d;
  logic          valid_d, last_d;
  logic          hs, pop, push, drop, full, more;
  logic          cur_mem, nxt_mem;
  logic [7:0]    nxt_masks;
  logic          unused_order;

  assign hs     = trace_valid_o && trace_ready_i;
  assign pop    = hs && trace_last_o;
  assign full   = (level_q == LW'(Depth));
  assign push   = rvfi_valid_i && (!full || pop);
  assign drop   = rvfi_valid_i && full && !pop;
  assign rd_nxt = rd_ptr + 1'b1;
  // A record written in the same cycle as the final pop is forwarded so packets stay back-to-back.
  assign more      = (level_q > LW'(1)) || push;
  assign next_head = (level_q > LW'(1)) ? mem_q[rd_nxt] : wr_rec;
  assign unused_order = ^rvfi_order_i[63:6];

  always_comb begin
    wr_rec          = '0;
    wr_rec.order    = rvfi_order_i[5:0];
    wr_rec.insn     = rvfi_insn_i;
    wr_rec.pc       = rvfi_pc_rdata_i;
    wr_rec.rd_addr  = rvfi_rd_addr_i;
    wr_rec.rd_wdata = (rvfi_rd_addr_i == 5'd0) ? 32'h0 : rvfi_rd_wdata_i;
    wr_rec.trap     = rvfi_trap_i;
    wr_rec.intr     = rvfi_intr_i;
    wr_rec.halt     = rvfi_halt_i;
    wr_rec.mode     = rvfi_mode_i;
    wr_rec.ovf      = ovf_q;
`ifdef IBEX_RVFI_TRACE_MEM_EN
    wr_rec.rmask    = rvfi_mem_rmask_i;
    wr_rec.wmask    = rvfi_mem_wmask_i;
    wr_rec.mem_addr = rvfi_mem_addr_i;
    wr_rec.mem_data = (|rvfi_mem_wmask_i) ? rvfi_mem_wdata_i : rvfi_mem_rdata_i;
`endif
  end

`ifdef IBEX_RVFI_TRACE_MEM_EN
  assign cur_mem   = |(cur_q.rmask | cur_q.wmask);
  assign nxt_mem   = |(nxt_rec.rmask | nxt_rec.wmask);
  assign nxt_masks = {nxt_rec.rmask, nxt_rec.wmask};
`else
  logic unused_mem;
  assign unused_mem = ^{rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i,
                        rvfi_mem_rdata_i, rvfi_mem_wdata_i};
  assign cur_mem    = 1'b0;
  assign nxt_mem    = 1'b0;
  assign nxt_masks  = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    nxt_rec = cur_q;
    unique case (state_q)
      IDLE: if (level_q != '0) begin
        state_d = HDR;
        nxt_rec = mem_q[rd_ptr];
      end
      HDR:  if (hs) state_d = PC;
      PC:   if (hs) state_d = INSN;
      INSN: if (hs) state_d = WDATA;
      WDATA: if (hs) begin
        if (cur_mem)   state_d = MADDR;
        else if (more) begin state_d = HDR; nxt_rec = next_head; end
        else           state_d = IDLE;
      end
      MADDR: if (hs) state_d = MDATA;
      MDATA: if (hs) begin
        if (more) begin state_d = HDR; nxt_rec = next_head; end
        else            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output words are computed from the next state so the stream ports come straight from flops.
  always_comb begin
    data_d = '0;
    unique case (state_d)
      HDR:   data_d = {4'hA, (nxt_mem ? 3'd6 : 3'd4), nxt_rec.mode, nxt_rec.trap, nxt_rec.intr,
                       nxt_rec.halt, nxt_rec.ovf, nxt_rec.rd_addr, nxt_masks, nxt_rec.order};
      PC:    data_d = nxt_rec.pc;
      INSN:  data_d = nxt_rec.insn;
      WDATA: data_d = nxt_rec.rd_wdata;
`ifdef IBEX_RVFI_TRACE_MEM_EN
      MADDR: data_d = nxt_rec.mem_addr;
      MDATA: data_d = nxt_rec.mem_data;
`endif
      default: data_d = '0;
    endcase
    valid_d = (state_d != IDLE);
    last_d  = ((state_d == WDATA) && !nxt_mem) || (state_d == MDATA);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      trace_valid_o <= 1'b0;
      trace_last_o  <= 1'b0;
      trace_data_o  <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      ovf_q         <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      cur_q         <= nxt_rec;
      trace_valid_o <= valid_d;
      trace_last_o  <= last_d;
      trace_data_o  <= data_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      level_q <= level_q + LW'(push) - LW'(pop);
      if (push)      ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr] <= wr_rec;
  end

  assign drop_cnt_o   = drop_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_packer.sv
// Bench for ibex_rvfi_trace_packer: queue-based packet model checked every cycle, plus directed literal cases.
module tb_ibex_rvfi_trace_packer;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          rvfi_valid_i = 1'b0;
  logic [63:0]   rvfi_order_i = '0;
  logic [31:0]   rvfi_insn_i = '0, rvfi_pc_rdata_i = '0, rvfi_rd_wdata_i = '0;
  logic [4:0]    rvfi_rd_addr_i = '0;
  logic          rvfi_trap_i = 1'b0, rvfi_intr_i = 1'b0, rvfi_halt_i = 1'b0;
  logic [1:0]    rvfi_mode_i = '0;
  logic [31:0]   rvfi_mem_addr_i = '0, rvfi_mem_rdata_i = '0, rvfi_mem_wdata_i = '0;
  logic [3:0]    rvfi_mem_rmask_i = '0, rvfi_mem_wmask_i = '0;
  logic          trace_valid_o, trace_last_o;
  logic          trace_ready_i = 1'b0;
  logic [31:0]   trace_data_o;
  logic [15:0]   drop_cnt_o;
  logic [LW-1:0] fifo_level_o;

  ibex_rvfi_trace_packer #(.Depth(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i),
    .rvfi_insn_i(rvfi_insn_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
    .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_trap_i(rvfi_trap_i), .rvfi_intr_i(rvfi_intr_i),
    .rvfi_halt_i(rvfi_halt_i), .rvfi_mode_i(rvfi_mode_i), .rvfi_mem_addr_i(rvfi_mem_addr_i),
    .rvfi_mem_rmask_i(rvfi_mem_rmask_i), .rvfi_mem_wmask_i(rvfi_mem_wmask_i),
    .rvfi_mem_rdata_i(rvfi_mem_rdata_i), .rvfi_mem_wdata_i(rvfi_mem_wdata_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i), .trace_data_o(trace_data_o),
    .trace_last_o(trace_last_o), .drop_cnt_o(drop_cnt_o), .fifo_level_o(fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]  order;
    logic [31:0] insn, pc, wd, maddr, mrd, mwd;
    logic [4:0]  rd;
    logic        trap, intr, halt, ovf;
    logic [1:0]  mode;
    logic [3:0]  rm, wm;
  } mrec_t;

  mrec_t       q[$];
  logic [31:0] cur[$];
  logic [31:0] hdr_log[$];
  logic [31:0] wlog[$];
  int          nvec = 0, nerr = 0;
  int unsigned m_drop = 0;
  bit          m_ovf = 0, armed = 0, after_rst = 0, stall_prev = 0, exp_valid = 0, pkt_start = 1;
  bit          hs, pop, push;
  int          lvl;
  logic [31:0] prev_data, w;
  logic        prev_last;
  mrec_t       mr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Packet contents straight from the field layout: header, pc, insn, rd data, then optional memory words.
  task automatic build(input mrec_t r);
    logic [31:0] h;
    bit m;
    int cnt;
    m = 0;
`ifdef IBEX_RVFI_TRACE_MEM_EN
    m = (r.rm != 4'h0) || (r.wm != 4'h0);
`endif
    cnt = m ? 6 : 4;
    h = 32'hA000_0000 + (cnt << 25) + (32'(r.mode) << 23) + (32'(r.trap) << 22) + (32'(r.intr) << 21)
      + (32'(r.halt) << 20) + (32'(r.ovf) << 19) + (32'(r.rd) << 14) + 32'(r.order);
    if (m) h = h + (32'(r.rm) << 10) + (32'(r.wm) << 6);
    cur.push_back(h);
    cur.push_back(r.pc);
    cur.push_back(r.insn);
    cur.push_back((r.rd == 5'd0) ? 32'h0 : r.wd);
    if (m) begin
      cur.push_back(r.maddr);
      cur.push_back((r.wm != 4'h0) ? r.mwd : r.mrd);
    end
  endtask

  always @(negedge clk_i) begin
    pop = 0;
    if (armed) begin
      chk("valid", 32'(trace_valid_o), 32'(exp_valid));
      chk("level", 32'(fifo_level_o), q.size());
      chk("drop_cnt", 32'(drop_cnt_o), m_drop);
      if (after_rst) begin
        chk("rst_data", trace_data_o, 32'h0);
        chk("rst_last", 32'(trace_last_o), 32'h0);
      end
      if (stall_prev) begin
        chk("hold_data", trace_data_o, prev_data);
        chk("hold_last", 32'(trace_last_o), 32'(prev_last));
      end
      hs = trace_valid_o && trace_ready_i;
      if (hs) begin
        if (cur.size() == 0 && q.size() > 0) build(q[0]);
        if (cur.size() == 0) flag_fail("spurious_word");
        else begin
          w = cur.pop_front();
          chk("word", trace_data_o, w);
          chk("last", 32'(trace_last_o), 32'(cur.size() == 0));
          pop = (cur.size() == 0);
        end
        if (pkt_start) hdr_log.push_back(trace_data_o);
        wlog.push_back(trace_data_o);
        pkt_start = trace_last_o;
      end
    end
    if (armed || rst_i) begin
      lvl = q.size();
      if (pop) mr = q.pop_front();
      push = rvfi_valid_i && (lvl < DEPTH || pop);
      if (push) begin
        mr.order = rvfi_order_i[5:0]; mr.insn = rvfi_insn_i; mr.pc = rvfi_pc_rdata_i;
        mr.wd = rvfi_rd_wdata_i; mr.rd = rvfi_rd_addr_i; mr.trap = rvfi_trap_i;
        mr.intr = rvfi_intr_i; mr.halt = rvfi_halt_i; mr.mode = rvfi_mode_i;
        mr.maddr = rvfi_mem_addr_i; mr.mrd = rvfi_mem_rdata_i; mr.mwd = rvfi_mem_wdata_i;
        mr.rm = rvfi_mem_rmask_i; mr.wm = rvfi_mem_wmask_i; mr.ovf = m_ovf;
        m_ovf = 0;
        q.push_back(mr);
      end else if (rvfi_valid_i) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      exp_valid = ((lvl - int'(pop)) > 0) || (pop && push);
      after_rst = 0;
      if (rst_i) begin
        q.delete(); cur.delete();
        m_drop = 0; m_ovf = 0; exp_valid = 0;
        after_rst = 1; pkt_start = 1; armed = 1;
      end
      stall_prev = !rst_i && trace_valid_o && !trace_ready_i;
      prev_data  = trace_data_o;
      prev_last  = trace_last_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_rec();
    rvfi_order_i     = {$urandom, $urandom};
    rvfi_insn_i      = $urandom;
    rvfi_pc_rdata_i  = $urandom;
    rvfi_rd_addr_i   = 5'($urandom);
    rvfi_rd_wdata_i  = $urandom;
    rvfi_trap_i      = 1'($urandom);
    rvfi_intr_i      = 1'($urandom);
    rvfi_halt_i      = 1'($urandom);
    rvfi_mode_i      = 2'($urandom);
    rvfi_mem_addr_i  = $urandom;
    rvfi_mem_rmask_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    rvfi_mem_wmask_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    rvfi_mem_rdata_i = $urandom;
    rvfi_mem_wdata_i = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((fifo_level_o != '0 || trace_valid_o) && n < 600) begin tick(); n++; end
    if (n >= 600) flag_fail("drain_timeout");
  endtask

  int vprob, rprob, n;

  initial begin
    rst_i = 1'b1;
    tick(); tick();
    chk("reset_valid", 32'(trace_valid_o), 32'h0);
    chk("reset_level", 32'(fifo_level_o), 32'h0);
    chk("reset_drop", 32'(drop_cnt_o), 32'h0);
    chk("reset_data", trace_data_o, 32'h0);
    rst_i = 1'b0;

    // single record, literal words and latency
    rand_rec();
    rvfi_pc_rdata_i = 32'h100; rvfi_insn_i = 32'h0050_0093; rvfi_rd_addr_i = 5'd1;
    rvfi_rd_wdata_i = 32'd5; rvfi_order_i = 64'd3; rvfi_mode_i = 2'd0;
    rvfi_trap_i = 0; rvfi_intr_i = 0; rvfi_halt_i = 0;
    rvfi_mem_rmask_i = 4'h0; rvfi_mem_wmask_i = 4'h0;
    trace_ready_i = 1'b1; rvfi_valid_i = 1'b1;
    tick();
    rvfi_valid_i = 1'b0;
    chk("lat_e0_valid", 32'(trace_valid_o), 32'h0);
    tick();
    chk("w0_valid", 32'(trace_valid_o), 32'h1);
    chk("w0", trace_data_o, 32'hA800_4003);
    chk("w0_last", 32'(trace_last_o), 32'h0);
    tick();
    chk("w1", trace_data_o, 32'h0000_0100);
    tick();
    chk("w2", trace_data_o, 32'h0050_0093);
    chk("w2_last", 32'(trace_last_o), 32'h0);
    tick();
    chk("w3", trace_data_o, 32'h0000_0005);
    chk("w3_last", 32'(trace_last_o), 32'h1);
    tick();
    chk("after_pkt_valid", 32'(trace_valid_o), 32'h0);

    // overflow: 10 retirements into 8 slots
    trace_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin rand_rec(); rvfi_valid_i = 1'b1; tick(); end
    rvfi_valid_i = 1'b0;
    tick();
    chk("ovf_level", 32'(fifo_level_o), 32'd8);
    chk("ovf_drop", 32'(drop_cnt_o), 32'd2);
    hdr_log.delete();
    trace_ready_i = 1'b1;
    repeat (6) tick();
    rand_rec(); rvfi_valid_i = 1'b1; tick(); rvfi_valid_i = 1'b0;
    wait_idle();
    chk("ovf_pkts", hdr_log.size(), 32'd9);
    if (hdr_log.size() >= 9) begin
      for (int i = 0; i < 8; i++) chk("ovf_flag_clear", 32'(hdr_log[i][19]), 32'h0);
      chk("ovf_flag_set", 32'(hdr_log[8][19]), 32'h1);
    end

    // memory words
    hdr_log.delete(); wlog.delete();
    rand_rec();
    rvfi_rd_addr_i = 5'd0; rvfi_rd_wdata_i = 32'h1234_5678;
    rvfi_mem_wmask_i = 4'hF; rvfi_mem_rmask_i = 4'h0; rvfi_mem_addr_i = 32'h2000;
    rvfi_mem_wdata_i = 32'hDEAD_BEEF; rvfi_mem_rdata_i = 32'h5555_AAAA;
    rvfi_valid_i = 1'b1; tick(); rvfi_valid_i = 1'b0;
    wait_idle();
`ifdef IBEX_RVFI_TRACE_MEM_EN
    chk("mem_nwords", wlog.size(), 32'd6);
    if (wlog.size() >= 6) begin
      chk("mem_cnt", 32'(wlog[0][27:25]), 32'd6);
      chk("mem_w3", wlog[3], 32'h0);
      chk("mem_w4", wlog[4], 32'h2000);
      chk("mem_w5", wlog[5], 32'hDEAD_BEEF);
    end
`else
    chk("mem_nwords", wlog.size(), 32'd4);
    if (wlog.size() >= 4) begin
      chk("mem_cnt", 32'(wlog[0][27:25]), 32'd4);
      chk("mem_masks", 32'(wlog[0][13:6]), 32'h0);
      chk("mem_w3", wlog[3], 32'h0);
    end
`endif

    // full FIFO, retirement on the final-word handshake
    trace_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin rand_rec(); rvfi_valid_i = 1'b1; tick(); end
    rvfi_valid_i = 1'b0;
    tick();
    chk("full_level", 32'(fifo_level_o), 32'd8);
    trace_ready_i = 1'b1;
    n = 0;
    while (!(trace_valid_o && trace_last_o) && n < 50) begin tick(); n++; end
    if (n >= 50) flag_fail("last_timeout");
    rand_rec(); rvfi_valid_i = 1'b1; tick(); rvfi_valid_i = 1'b0;
    chk("simul_level", 32'(fifo_level_o), 32'd8);
    chk("simul_drop", 32'(drop_cnt_o), 32'd2);
    wait_idle();

    // reset while W2 is presented
    rand_rec(); rvfi_valid_i = 1'b1; tick(); rvfi_valid_i = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_w2", trace_data_o, rvfi_insn_i);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("midrst_valid", 32'(trace_valid_o), 32'h0);
    chk("midrst_level", 32'(fifo_level_o), 32'h0);
    chk("midrst_drop", 32'(drop_cnt_o), 32'h0);
    hdr_log.delete();
    rand_rec(); rvfi_valid_i = 1'b1; tick(); rvfi_valid_i = 1'b0;
    wait_idle();
    chk("midrst_pkts", hdr_log.size(), 32'd1);
    if (hdr_log.size() >= 1) begin
      chk("midrst_hdr_tag", 32'(hdr_log[0][31:28]), 32'hA);
      chk("midrst_hdr_ovf", 32'(hdr_log[0][19]), 32'h0);
    end

    // randomized traffic with varying load and back-pressure
    vprob = 50; rprob = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        vprob = (c % 750 == 0) ? 90 : ((c % 500 == 0) ? 20 : 50);
        rprob = ($urandom_range(0, 2) == 0) ? 100 : (($urandom_range(0, 1) == 0) ? 15 : 60);
      end
      rand_rec();
      rvfi_valid_i  = ($urandom_range(0, 99) < vprob);
      trace_ready_i = ($urandom_range(0, 99) < rprob);
      rst_i         = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst_i = 1'b0; rvfi_valid_i = 1'b0; trace_ready_i = 1'b1;
    wait_idle();
    tick();
    chk("final_level", 32'(fifo_level_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
